// File: rtl/secure_reg_host_pkg.sv
// Shared types for the secure-register host sequencer: command opcodes,
// target cfg bit positions and FSM states.
package secure_reg_pkg;

  typedef enum logic [1:0] {
    OP_WRITE   = 2'd0,
    OP_READ    = 2'd1,
    OP_LOCK    = 2'd2,
    OP_ILLEGAL = 2'd3
  } op_e;

  localparam int CFG_RE   = 0;
  localparam int CFG_WE   = 1;
  localparam int CFG_LOCK = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  // Strobe pattern presented to the target while an access is in flight.
  function automatic logic [2:0] op_cfg(input op_e op);
    logic [2:0] c;
    c = 3'b000;
    case (op)
      OP_WRITE: c[CFG_WE]   = 1'b1;
      OP_READ:  c[CFG_RE]   = 1'b1;
      OP_LOCK:  c[CFG_LOCK] = 1'b1;
      default:  c = 3'b000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/secure_reg_host_if.sv
// Host-side command/response handshake bundle for secure_reg_host.
interface secure_reg_host_if;

  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_rdata;
  logic       rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_wdata, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_wdata, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/secure_reg_host_sat_counter.sv
// Up-counter that sticks at all-ones; used to tally rejected commands.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/secure_reg_host.sv
// Initiator-side sequencer for the lockable secure-register target: holds
// cfg/wd for a settle window, samples out, and returns a response.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | cmd_ready high, cfg at rest, waiting for a command
//  ST_DRIVE | cfg/wd held on the target while the settle counter runs down
//  ST_RESP  | rsp_valid high, response held until rsp_ready
module secure_reg_host
  import secure_reg_pkg::*;
#(
  parameter int SETTLE = 3,
  parameter int ERRW   = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  secure_reg_host_if.slave host,
  output logic [2:0]      cfg,
  output logic [7:0]      wd,
  input  logic [7:0]      out,
  output logic            locked,
  output logic [ERRW-1:0] err_cnt
);

  state_e     state_q;
  state_e     state_d;
  logic [3:0] cnt_q;
  op_e        op_q;
  logic [7:0] wd_q;
  logic [7:0] rdata_q;
  logic       err_q;
  logic       locked_q;
  logic       rdy_q;

  op_e  op_in;
  logic accept;
  logic reject;
  logic cnt_done;

  assign op_in    = op_e'(host.cmd_op);
  assign accept   = host.cmd_valid && host.cmd_ready;
  assign reject   = (op_in == OP_ILLEGAL) || locked_q;
  assign cnt_done = (cnt_q == 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = reject ? ST_RESP : ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (cnt_done) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (host.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // rdy_q keeps cmd_ready low until the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q    <= 1'b0;
      cnt_q    <= 4'd0;
      op_q     <= OP_WRITE;
      wd_q     <= 8'h00;
      rdata_q  <= 8'h00;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (reject) begin
              rdata_q <= 8'h00;
              err_q   <= 1'b1;
            end else begin
              op_q  <= op_in;
              cnt_q <= 4'(SETTLE - 1);
              wd_q  <= (op_in == OP_WRITE) ? host.cmd_wdata : 8'h00;
            end
          end
        end
        ST_DRIVE: begin
          if (cnt_done) begin
            rdata_q <= (op_q == OP_READ) ? out : 8'h00;
            err_q   <= 1'b0;
            if (op_q == OP_LOCK) begin
              locked_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    host.cmd_ready = rdy_q && (state_q == ST_IDLE);
    host.rsp_valid = (state_q == ST_RESP);
    host.rsp_rdata = rdata_q;
    host.rsp_err   = err_q;
    cfg            = 3'b000;
    cfg[CFG_LOCK]  = locked_q;
    wd             = 8'h00;
    if (state_q == ST_DRIVE) begin
      cfg = op_cfg(op_q);
      wd  = wd_q;
    end
  end

  assign locked = locked_q;

  sat_counter #(
    .W (ERRW)
  ) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (accept && reject),
    .count (err_cnt)
  );

endmodule
